// File: rtl/trans_serializer.sv
// Buffers 128-bit transactions in a FIFO and serializes each one MSB byte first
// over a ready/valid byte stream, with drop and transmit accounting.
module trans_serializer #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [127:0]                  data_i,
   input  logic                          valid_i,
   output logic [7:0]                    byte_o,
   output logic                          byte_valid_o,
   input  logic                          byte_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o,
   output logic [15:0]                   drop_cnt_o,
   output logic [15:0]                   tx_cnt_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   typedef enum logic {IDLE, SEND} state_e;

   state_e           state_q, state_d;
   logic [127:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [127:0]     shift_q, shift_d;
   logic [3:0]       idx_q, idx_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic [15:0]      tx_cnt_q, tx_cnt_d;

   logic             last_byte;
   logic             pop;
   logic             push;
   logic             drop;

   // A pop frees a slot in the same cycle, so a push at full level is still accepted.
   assign last_byte = (state_q == SEND) && byte_ready_i && (idx_q == 4'hF);
   assign pop       = (level_q != '0) && ((state_q == IDLE) || last_byte);
   assign push      = valid_i && ((level_q != DEPTH_L) || pop);
   assign drop      = valid_i && !push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (level_q != '0) state_d = SEND;
         SEND:    if (last_byte && (level_q == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_d    = shift_q;
      idx_d      = idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      tx_cnt_d   = tx_cnt_q;

      if (pop) begin
         shift_d  = mem_q[rd_ptr_q];
         idx_d    = '0;
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else if ((state_q == SEND) && byte_ready_i && !last_byte) begin
         shift_d = {shift_q[119:0], 8'h00};
         idx_d   = idx_q + 4'd1;
      end

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (push && !pop) level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
      end
      if (last_byte) tx_cnt_d = tx_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         tx_cnt_q   <= '0;
      end else begin
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   assign byte_o       = shift_q[127:120];
   assign byte_valid_o = (state_q == SEND);
   assign fifo_level_o = level_q;
   assign overflow_o   = overflow_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign tx_cnt_o     = tx_cnt_q;

endmodule

// File: doc/trans_serializer.md
TRANS_SERIALIZER -- requirements
Module: trans_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of 128-bit transaction entries buffered; SHALL be a power of two, 2..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-004 data_i  input  128  validated transaction from the upstream validator stage.
REQ-005 valid_i  input  1  single-cycle strobe qualifying data_i; upstream applies no backpressure.
REQ-006 byte_o  output  8  current output byte.
REQ-007 byte_valid_o  output  1  byte_o holds a valid byte.
REQ-008 byte_ready_i  input  1  downstream sink accepts byte_o this cycle.
REQ-009 fifo_level_o  output  $clog2(FIFO_DEPTH)+1  entries currently stored.
REQ-010 overflow_o  output  1  sticky flag: at least one transaction dropped.
REQ-011 drop_cnt_o  output  16  dropped transactions, saturating at 16'hFFFF.
REQ-012 tx_cnt_o  output  16  fully sent transactions, wraps modulo 2^16.

Function
REQ-013 All outputs SHALL be driven from registers; no combinational input-to-output path.
REQ-014 FIFO push: valid_i=1 and (level<FIFO_DEPTH or a pop occurs the same cycle) SHALL write data_i at the write pointer; pointers wrap modulo FIFO_DEPTH.
REQ-015 valid_i=1 with level==FIFO_DEPTH and no same-cycle pop SHALL drop data_i, set overflow_o, and increment drop_cnt_o (saturating); FIFO contents unchanged.
REQ-016 Serializer FSM states: IDLE, SEND.
REQ-017 IDLE: byte_valid_o=0; if level>0, pop head into 128-bit shift register, byte index=0, go to SEND.
REQ-018 SEND: byte_valid_o=1, byte_o=shift register bits [127:120] (MSB byte first, byte 0 = data_i[127:120], byte 15 = data_i[7:0]).
REQ-019 SEND with byte_ready_i=0: byte_o, byte_valid_o, index SHALL hold unchanged.
REQ-020 SEND with byte_ready_i=1 and index<15: shift register left by 8, index+1.
REQ-021 SEND with byte_ready_i=1 and index==15: tx_cnt_o+1; if level>0 pop next entry, index=0, remain SEND (no idle bubble); else go to IDLE.
REQ-022 A pop (REQ-017/021) and a push SHALL be allowed in the same cycle; level unchanged in that case, including at level==FIFO_DEPTH (push accepted, no drop).
REQ-023 Latency: valid_i at cycle N into empty FIFO with FSM in IDLE SHALL give byte_valid_o=1 with byte 0 at cycle N+2.
REQ-024 Throughput: with byte_ready_i held 1 and FIFO non-empty, one byte per cycle continuously, 16 cycles per transaction.
REQ-025 fifo_level_o SHALL reflect level after the cycle's push/pop, updated with the same edge.
REQ-026 overflow_o SHALL clear only on reset.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM=IDLE, byte_valid_o=0, byte_o=0, pointers=0, fifo_level_o=0, overflow_o=0, drop_cnt_o=0, tx_cnt_o=0, index=0.
REQ-028 Reset asserted mid-transaction SHALL discard the partial transaction and all buffered entries; no tx_cnt_o increment.
REQ-029 First push accepted on the first rising edge with rst_n=1.
REQ-030 FIFO storage array need not be reset.

Verification
REQ-031 Single: push 128'h00112233_44556677_8899AABB_CCDDEEFF at cycle N, byte_ready_i=1 -> bytes 00,11,...,FF on cycles N+2..N+17, tx_cnt_o=1, then byte_valid_o=0.
REQ-032 Back-to-back: push A then B on consecutive cycles, ready=1 -> 32 contiguous valid bytes, no bubble, tx_cnt_o=2.
REQ-033 Stall: ready=0 for 5 cycles at byte index 7 -> byte_o holds byte 7 for those cycles, sequence resumes intact.
REQ-034 Overflow: ready=0, FIFO_DEPTH=8, push 10 transactions -> FSM holds 1, fifo_level_o=8, drop 1, overflow_o=1, drop_cnt_o=1; release ready -> 9 transactions emitted in order.
REQ-035 Full push+pop: level=8, push coincides with pop at index 15 -> push accepted, level stays 8, drop_cnt_o unchanged.
REQ-036 Reset mid-send: assert rst_n=0 at byte 9 -> byte_valid_o=0 immediately, all counters 0, next push emits from byte 0.
